pll_drp_ctrl: RTL and testbench

Configuration and lock sequencer for the PLL model's frequency generators. It exposes a DRP-style register port (address, data-in, enable, write-enable, data-out, ready) that loads new multiplier, divisor and per-output divisor values into shadow registers. On an explicit apply command, it copies the shadow registers to the active `M`/`D`/`O_1000` buses, holds the generators in reset, and then drives `LOCKED` once `period_stable` has been continuously high for a programmable number of cycles. It also owns the generators' `RST` and `PWRDWN` inputs.

---
 rtl/pll_drp_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
// DRP shadow/active ratio registers plus generator reset, power-down and lock sequencing.
// Access completes DRDY_LATENCY cycles after DEN; strobes during an access are dropped and flag BUSY_ERR.
module pll_drp_ctrl #(
  parameter int NUM_OUT      = 4,
  parameter int M_INIT       = 2,
  parameter int D_INIT       = 1,
  parameter int O_INIT       = 8,
  parameter int RST_CYCLES   = 4,
  parameter int LOCK_CYCLES  = 16,
  parameter int DRDY_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [6:0]             DADDR,
  input  logic [15:0]            DI,
  input  logic                   DEN,
  input  logic                   DWE,
  output logic [15:0]            DO,
  output logic                   DRDY,
  input  logic                   period_stable,
  output logic [31:0]            M,
  output logic [31:0]            D,
  output logic [32*NUM_OUT-1:0]  O_1000,
  output logic                   fg_RST,
  output logic                   fg_PWRDWN,
  output logic                   LOCKED
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int AW = $clog2(DRDY_LATENCY + 1);

  typedef enum logic [2:0] {
    S_PWRDN  = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_COUNT  = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] rst_cnt, rst_cnt_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;

  logic          busy;
  logic [AW-1:0] acc_cnt;
  logic [6:0]    req_addr;
  logic [15:0]   req_di;
  logic          req_we;

  logic [6:0]    sh_m, act_m;
  logic [5:0]    sh_d, act_d;
  logic [10:0]   sh_o [NUM_OUT];
  logic [10:0]   act_o [NUM_OUT];
  logic          pd_req, range_err, busy_err;

  logic               wr, ctrl_wr, apply, clr_err, pd_eff, range_set;
  logic               m_ok, d_ok, o_ok, o_hit;
  logic [NUM_OUT-1:0] o_sel;
  logic [10:0]        o_rd;
  logic [15:0]        rd_dat;

  assign DRDY    = busy && (acc_cnt == AW'(DRDY_LATENCY));
  assign wr      = DRDY && req_we;
  assign ctrl_wr = wr && (req_addr == 7'h02);
  assign apply   = ctrl_wr && req_di[0];
  assign clr_err = ctrl_wr && req_di[2];
  assign pd_eff  = ctrl_wr ? req_di[1] : pd_req;

  assign m_ok = (req_di >= 16'd2) && (req_di <= 16'd64);
  assign d_ok = (req_di >= 16'd1) && (req_di <= 16'd56);
  assign o_ok = (req_di >= 16'd8) && (req_di <= 16'd1024);

  always_comb begin
    o_sel = '0;
    o_rd  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (req_addr == 7'(16 + i)) begin
        o_sel[i] = 1'b1;
        o_rd     = sh_o[i];
      end
    end
  end
  assign o_hit = |o_sel;

  assign range_set = wr && (((req_addr == 7'h00) && !m_ok) ||
                            ((req_addr == 7'h01) && !d_ok) ||
                            (o_hit && !o_ok));

  // Access tracker and register file; write effects land at the end of the DRDY cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      busy      <= 1'b0;
      acc_cnt   <= '0;
      req_addr  <= '0;
      req_di    <= '0;
      req_we    <= 1'b0;
      sh_m      <= 7'(M_INIT);
      act_m     <= 7'(M_INIT);
      sh_d      <= 6'(D_INIT);
      act_d     <= 6'(D_INIT);
      for (int i = 0; i < NUM_OUT; i++) begin
        sh_o[i]  <= 11'(O_INIT);
        act_o[i] <= 11'(O_INIT);
      end
      pd_req    <= 1'b0;
      range_err <= 1'b0;
      busy_err  <= 1'b0;
    end else begin
      if (DEN && !busy) begin
        busy     <= 1'b1;
        acc_cnt  <= AW'(1);
        req_addr <= DADDR;
        req_di   <= DI;
        req_we   <= DWE;
      end else if (busy) begin
        if (DRDY) busy <= 1'b0;
        else      acc_cnt <= acc_cnt + AW'(1);
      end

      if (wr && (req_addr == 7'h00) && m_ok) sh_m <= req_di[6:0];
      if (wr && (req_addr == 7'h01) && d_ok) sh_d <= req_di[5:0];
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr && o_sel[i] && o_ok) sh_o[i] <= req_di[10:0];
      end

      if (apply) begin
        act_m <= sh_m;
        act_d <= sh_d;
        for (int i = 0; i < NUM_OUT; i++) act_o[i] <= sh_o[i];
      end

      pd_req    <= pd_eff;
      range_err <= (range_err && !clr_err) || range_set;
      busy_err  <= (busy_err && !clr_err) || (DEN && busy);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= S_RESET;
      rst_cnt  <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      rst_cnt  <= rst_cnt_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // Power-down dominates; apply or leaving power-down restarts the reset phase.
  always_comb begin
    state_n    = state;
    rst_cnt_n  = rst_cnt;
    lock_cnt_n = lock_cnt;
    if (pd_eff) begin
      state_n    = S_PWRDN;
      rst_cnt_n  = '0;
      lock_cnt_n = '0;
    end else if ((state == S_PWRDN) || apply) begin
      state_n    = S_RESET;
      rst_cnt_n  = '0;
      lock_cnt_n = '0;
    end else begin
      unique case (state)
        S_RESET: begin
          if (rst_cnt >= RW'(RST_CYCLES - 1)) begin
            state_n   = S_WAIT;
            rst_cnt_n = '0;
          end else begin
            rst_cnt_n = rst_cnt + RW'(1);
          end
        end
        S_WAIT: begin
          if (period_stable) begin
            state_n    = S_COUNT;
            lock_cnt_n = '0;
          end
        end
        S_COUNT: begin
          if (!period_stable) begin
            state_n    = S_WAIT;
            lock_cnt_n = '0;
          end else if (lock_cnt >= LW'(LOCK_CYCLES - 1)) begin
            state_n    = S_LOCKED;
            lock_cnt_n = LW'(LOCK_CYCLES);
          end else begin
            lock_cnt_n = lock_cnt + LW'(1);
          end
        end
        S_LOCKED: begin
          if (!period_stable) begin
            state_n    = S_WAIT;
            lock_cnt_n = '0;
          end
        end
        default: state_n = S_RESET;
      endcase
    end
  end

  assign fg_PWRDWN = (state == S_PWRDN);
  assign fg_RST    = (state == S_PWRDN) || (state == S_RESET);
  assign LOCKED    = (state == S_LOCKED);

  always_comb begin
    rd_dat = '0;
    case (req_addr)
      7'h00:   rd_dat = {9'b0, sh_m};
      7'h01:   rd_dat = {10'b0, sh_d};
      7'h02:   rd_dat = {14'b0, pd_req, 1'b0};
      7'h03:   rd_dat = {10'b0, busy_err, range_err, state, LOCKED};
      default: if (o_hit) rd_dat = {5'b0, o_rd};
    endcase
  end

  assign DO = (DRDY && !req_we) ? rd_dat : 16'h0;
  assign M  = {25'b0, act_m};
  assign D  = {26'b0, act_d};

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_o
    assign O_1000[32*g +: 32] = 32'(act_o[g]) * 32'd125;
  end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: directed register/lock scenarios with literal expectations, then random
// DRP traffic and period_stable activity checked every cycle against a timer-based behavioural model.
module tb_pll_drp_ctrl;
  localparam int NUM_OUT = 4;
  localparam int RSTC    = 4;
  localparam int LOCKC   = 16;
  localparam int LAT     = 2;

  logic                  clk = 1'b0;
  logic                  RST;
  logic [6:0]            DADDR;
  logic [15:0]           DI;
  logic                  DEN;
  logic                  DWE;
  logic [15:0]           DO;
  logic                  DRDY;
  logic                  period_stable;
  logic [31:0]           M;
  logic [31:0]           D;
  logic [32*NUM_OUT-1:0] O_1000;
  logic                  fg_RST;
  logic                  fg_PWRDWN;
  logic                  LOCKED;

  int n_tests = 0;
  int n_fail  = 0;

  pll_drp_ctrl #(
    .NUM_OUT(NUM_OUT), .M_INIT(2), .D_INIT(1), .O_INIT(8),
    .RST_CYCLES(RSTC), .LOCK_CYCLES(LOCKC), .DRDY_LATENCY(LAT)
  ) dut (
    .clk(clk), .RST(RST), .DADDR(DADDR), .DI(DI), .DEN(DEN), .DWE(DWE),
    .DO(DO), .DRDY(DRDY), .period_stable(period_stable),
    .M(M), .D(D), .O_1000(O_1000),
    .fg_RST(fg_RST), .fg_PWRDWN(fg_PWRDWN), .LOCKED(LOCKED)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Model: sequencing is expressed as remaining reset cycles and the length of the
  // current run of stable samples since the reset phase ended.
  bit          check_en = 1'b0;
  int          cyc = 0;
  bit          inflight;
  int          due;
  logic [6:0]  q_addr;
  logic [15:0] q_di;
  bit          q_we;
  int          m_sh, d_sh, m_act, d_act;
  int          o_sh [NUM_OUT];
  int          o_act [NUM_OUT];
  bit          pd_req, r_err, b_err, pd;
  int          rst_left, run;

  function automatic int code();
    if (pd) return 0;
    if (rst_left > 0) return 1;
    if (run == 0) return 2;
    if (run <= LOCKC) return 3;
    return 4;
  endfunction

  function automatic logic [15:0] read_val(input logic [6:0] a);
    int v;
    v = 0;
    if (a == 7'h00) v = m_sh;
    else if (a == 7'h01) v = d_sh;
    else if (a == 7'h02) v = pd_req ? 2 : 0;
    else if (a == 7'h03) v = (b_err ? 32 : 0) + (r_err ? 16 : 0) + code() * 2 + (code() == 4 ? 1 : 0);
    else if (int'(a) >= 16 && int'(a) < 16 + NUM_OUT) v = o_sh[int'(a) - 16];
    return 16'(v);
  endfunction

  task automatic model_step();
    bit apply, busy_hit;
    apply = 1'b0;
    if (RST) begin
      check_en = 1'b1;
      inflight = 1'b0;
      m_sh = 2; m_act = 2; d_sh = 1; d_act = 1;
      for (int i = 0; i < NUM_OUT; i++) begin o_sh[i] = 8; o_act[i] = 8; end
      pd_req = 1'b0; r_err = 1'b0; b_err = 1'b0;
      pd = 1'b0; rst_left = RSTC; run = 0;
    end else begin
      busy_hit = DEN && inflight;
      if (inflight && due == cyc) begin
        inflight = 1'b0;
        if (q_we) begin
          if (q_addr == 7'h00) begin
            if (q_di >= 2 && q_di <= 64) m_sh = int'(q_di); else r_err = 1'b1;
          end else if (q_addr == 7'h01) begin
            if (q_di >= 1 && q_di <= 56) d_sh = int'(q_di); else r_err = 1'b1;
          end else if (q_addr == 7'h02) begin
            pd_req = q_di[1];
            apply  = q_di[0];
            if (q_di[2]) begin r_err = 1'b0; b_err = 1'b0; end
          end else if (int'(q_addr) >= 16 && int'(q_addr) < 16 + NUM_OUT) begin
            if (q_di >= 8 && q_di <= 1024) o_sh[int'(q_addr) - 16] = int'(q_di); else r_err = 1'b1;
          end
        end
      end
      if (DEN) begin
        if (busy_hit) b_err = 1'b1;
        else begin
          inflight = 1'b1; due = cyc + LAT;
          q_addr = DADDR; q_di = DI; q_we = DWE;
        end
      end
      if (apply) begin
        m_act = m_sh; d_act = d_sh;
        for (int i = 0; i < NUM_OUT; i++) o_act[i] = o_sh[i];
      end
      if (pd_req) begin
        pd = 1'b1; rst_left = RSTC; run = 0;
      end else if (pd || apply) begin
        pd = 1'b0; rst_left = RSTC; run = 0;
      end else if (rst_left > 0) begin
        rst_left--;
      end else begin
        run = period_stable ? (run < 1000 ? run + 1 : run) : 0;
      end
    end
    cyc++;
  endtask

  logic [19:0]           exp_ctl, obs_ctl;
  logic [32*NUM_OUT+63:0] exp_dat, obs_dat;
  logic                  exp_drdy;

  always @(negedge clk) begin
    if (check_en) begin
      exp_drdy = inflight && (due == cyc);
      exp_ctl  = {exp_drdy, (exp_drdy && !q_we) ? read_val(q_addr) : 16'h0,
                  pd || (rst_left > 0), pd, code() == 4};
      obs_ctl  = {DRDY, (exp_drdy && q_we) ? 16'h0 : DO, fg_RST, fg_PWRDWN, LOCKED};
      n_tests++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL ctl cyc %0d got %h want %h (drdy,do,rst,pwrdwn,locked)", cyc, obs_ctl, exp_ctl);
      end
      exp_dat = {32'(m_act), 32'(d_act), 128'b0};
      for (int i = 0; i < NUM_OUT; i++) exp_dat[32*i +: 32] = 32'(o_act[i] * 125);
      obs_dat = {M, D, O_1000};
      n_tests++;
      if (obs_dat !== exp_dat) begin
        n_fail++;
        $display("FAIL act cyc %0d got %h want %h", cyc, obs_dat, exp_dat);
      end
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drp_write(input logic [6:0] a, input logic [15:0] v);
    DADDR = a; DI = v; DWE = 1'b1; DEN = 1'b1;
    tick();
    DEN = 1'b0; DWE = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic drp_read(input logic [6:0] a, output logic [15:0] v);
    DADDR = a; DWE = 1'b0; DEN = 1'b1;
    tick();
    DEN = 1'b0;
    repeat (LAT - 1) tick();
    check("rd_drdy", 32'(DRDY), 32'd1);
    v = DO;
    tick();
  endtask

  task automatic measure_lock(input string nm, input int want_rst, input int want_lock);
    int n, r;
    n = 0; r = 0;
    while (LOCKED !== 1'b1 && n < 200) begin
      if (fg_RST === 1'b1) r++;
      tick();
      n++;
    end
    check({nm, "_rst_len"}, 32'(r), 32'(want_rst));
    check({nm, "_lock_at"}, 32'(n), 32'(want_lock));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv;
    int cnt, sel, r;
    RST = 1'b1; DADDR = '0; DI = '0; DEN = 1'b0; DWE = 1'b0; period_stable = 1'b1;
    tick(); tick();
    check("rst_drdy", 32'(DRDY), 32'd0);
    check("rst_do", 32'(DO), 32'd0);
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_fgrst", 32'(fg_RST), 32'd1);
    check("rst_pwrdwn", 32'(fg_PWRDWN), 32'd0);
    check("rst_m", M, 32'd2);
    check("rst_d", D, 32'd1);
    check("rst_o0", O_1000[31:0], 32'd1000);
    check("rst_o3", O_1000[127:96], 32'd1000);
    RST = 1'b0;
    measure_lock("boot", 4, 21);

    drp_write(7'h00, 16'd10);
    drp_write(7'h01, 16'd2);
    drp_write(7'h11, 16'd20);
    drp_read(7'h00, rv);
    check("rd_m_shadow", 32'(rv), 32'd10);
    check("m_before_apply", M, 32'd2);
    drp_write(7'h02, 16'h1);
    check("apply_m", M, 32'd10);
    check("apply_d", D, 32'd2);
    check("apply_o1", O_1000[63:32], 32'd2500);
    check("apply_o0", O_1000[31:0], 32'd1000);
    check("apply_locked", 32'(LOCKED), 32'd0);
    check("apply_fgrst", 32'(fg_RST), 32'd1);
    measure_lock("apply", 4, 21);

    drp_write(7'h00, 16'd65);
    drp_write(7'h10, 16'd7);
    drp_read(7'h00, rv);
    check("bad_m_kept", 32'(rv), 32'd10);
    drp_read(7'h10, rv);
    check("bad_o_kept", 32'(rv), 32'd8);
    drp_read(7'h03, rv);
    check("status_rangeerr", 32'(rv), 32'h19);
    drp_write(7'h02, 16'h4);
    drp_read(7'h03, rv);
    check("status_cleared", 32'(rv), 32'h09);

    DADDR = 7'h01; DWE = 1'b0; DEN = 1'b1;
    tick();
    DADDR = 7'h00;
    tick();
    DEN = 1'b0;
    check("busy_drdy", 32'(DRDY), 32'd1);
    check("busy_do", 32'(DO), 32'd2);
    tick();
    cnt = 0;
    repeat (4) begin cnt += int'(DRDY); tick(); end
    check("busy_extra_drdy", 32'(cnt), 32'd0);
    drp_read(7'h03, rv);
    check("status_busyerr", 32'(rv), 32'h29);
    drp_write(7'h02, 16'h4);

    period_stable = 1'b0;
    tick();
    period_stable = 1'b1;
    check("drop_locked", 32'(LOCKED), 32'd0);
    measure_lock("drop", 0, 17);

    drp_write(7'h02, 16'h2);
    check("pd_pwrdwn", 32'(fg_PWRDWN), 32'd1);
    check("pd_fgrst", 32'(fg_RST), 32'd1);
    check("pd_locked", 32'(LOCKED), 32'd0);
    drp_read(7'h03, rv);
    check("pd_status", 32'(rv), 32'h0);
    drp_read(7'h02, rv);
    check("pd_ctrl", 32'(rv), 32'h2);
    drp_write(7'h02, 16'h0);
    measure_lock("pdexit", 4, 21);

    for (int k = 0; k < 4000; k++) begin
      RST = ($urandom_range(0, 499) == 0);
      if (period_stable) begin
        if ($urandom_range(0, 39) == 0) period_stable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) period_stable = 1'b1;
      DEN = ($urandom_range(0, 5) == 0);
      DWE = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 9);
      r   = $urandom_range(0, 3);
      case (sel)
        0: begin DADDR = 7'h00; DI = 16'($urandom_range(0, 70)); end
        1: begin DADDR = 7'h01; DI = 16'($urandom_range(0, 60)); end
        2: begin
          DADDR = 7'h02;
          DI = {13'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
        end
        3: begin DADDR = 7'h03; DI = 16'($urandom); end
        4, 5, 6, 7: begin DADDR = 7'(16 + sel - 4); DI = 16'($urandom_range(0, 1100)); end
        8: begin DADDR = 7'h14; DI = 16'($urandom_range(0, 1100)); end
        default: begin DADDR = 7'(16'($urandom_range(32, 127))); DI = 16'($urandom); end
      endcase
      if (r == 0) DI = 16'($urandom);
      tick();
    end
    RST = 1'b0; DEN = 1'b0; DWE = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
